// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/bubble/flush sequencing for load-use, multi-cycle multiply and EX-resolved redirects
// Ports: clk, rst (async, active-high); ID_vld, ID_mux_sel (decode view); ID_EX_vld, ID_EX_is_load,
// ID_EX_is_mul, EX_br_taken (EX view); PC/IF_ID/ID_EX/EX_MEM stall-bubble-flush controls and
// EX_mul_last (combinational); stall_cycles, flush_events (registered perf counters).
module hazard_ctrl #(
    parameter int         MUL_LAT   = 4,
    parameter int         FETCH_LAT = 1,
    parameter logic [2:0] SEL_F1    = 3'd3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ID_vld,
    input  logic [8:0]  ID_mux_sel,
    input  logic        ID_EX_vld,
    input  logic        ID_EX_is_load,
    input  logic        ID_EX_is_mul,
    input  logic        EX_br_taken,
    output logic        PC_stall,
    output logic        IF_ID_stall,
    output logic        IF_ID_flush,
    output logic        ID_EX_stall,
    output logic        ID_EX_bubble,
    output logic        EX_MEM_bubble,
    output logic        EX_mul_last,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_events
);
    typedef enum logic [1:0] {RUN, MUL_BUSY, FLUSH} state_t;
    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] stall_cycles_q, stall_cycles_d, flush_events_q, flush_events_d;
    logic        run, mul_busy, lu, br, mul_go, lu_stall, mul_stall;
    always_comb begin
        run       = state_q == RUN;
        mul_busy  = state_q == MUL_BUSY;
        lu        = ID_vld & ID_EX_vld & ID_EX_is_load &
                    (ID_mux_sel[8:6] == SEL_F1 | ID_mux_sel[5:3] == SEL_F1 | ID_mux_sel[2:0] == SEL_F1);
        // Priority in RUN: a redirect kills ID, so it masks both multiply and load-use.
        br        = run & EX_br_taken & ID_EX_vld;
        mul_go    = run & ~br & ID_EX_vld & ID_EX_is_mul;
        lu_stall  = run & ~br & ~mul_go & lu;
        mul_stall = (mul_go & (MUL_LAT > 1)) | (mul_busy & (cnt_q != 4'd0));
        PC_stall      = mul_stall | lu_stall;
        IF_ID_stall   = mul_stall | lu_stall;
        ID_EX_stall   = mul_stall;
        EX_MEM_bubble = mul_stall;
        ID_EX_bubble  = br | lu_stall;
        IF_ID_flush   = br | (state_q == FLUSH);
        EX_mul_last   = (mul_go & (MUL_LAT == 1)) | (mul_busy & (cnt_q == 4'd0));
        state_d = state_q;
        cnt_d   = cnt_q;
        if (br && FETCH_LAT > 1) begin
            state_d = FLUSH;
            cnt_d   = 4'(FETCH_LAT - 2);
        end else if (mul_go && MUL_LAT > 1) begin
            state_d = MUL_BUSY;
            cnt_d   = 4'(MUL_LAT - 2);
        end else if (!run) begin
            // Both busy states count down to zero and leave after the cnt==0 cycle.
            state_d = (cnt_q == 4'd0) ? RUN : state_q;
            cnt_d   = (cnt_q == 4'd0) ? cnt_q : cnt_q - 4'd1;
        end
        stall_cycles_d = stall_cycles_q + {31'd0, PC_stall};
        flush_events_d = flush_events_q + {31'd0, br};
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= RUN;
            cnt_q          <= 4'd0;
            stall_cycles_q <= 32'd0;
            flush_events_q <= 32'd0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            stall_cycles_q <= stall_cycles_d;
            flush_events_q <= flush_events_d;
        end
    end
    assign stall_cycles = stall_cycles_q;
    assign flush_events = flush_events_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed scenarios plus randomized run against a cycle-count reference model
// Ports: none; drives two hazard_ctrl instances (MUL_LAT=4/FETCH_LAT=3 and MUL_LAT=8/FETCH_LAT=1).
module tb_hazard_ctrl;
    localparam logic [2:0] SEL_0 = 3'd0, SEL_IMM = 3'd2, SEL_F1 = 3'd3, SEL_F2 = 3'd4;
    // Output vector order: {PC_stall, IF_ID_stall, IF_ID_flush, ID_EX_stall, ID_EX_bubble, EX_MEM_bubble, EX_mul_last}
    localparam logic [6:0] O_LU = 7'b1100100, O_MUL = 7'b1101010, O_LAST = 7'b0000001,
                           O_BR = 7'b0010100, O_FL = 7'b0010000;

    logic clk = 1'b0, rst = 1'b0;
    logic ID_vld = 1'b0, ID_EX_vld = 1'b0, ID_EX_is_load = 1'b0, ID_EX_is_mul = 1'b0, EX_br_taken = 1'b0;
    logic [8:0] ID_mux_sel = 9'd0;
    logic [6:0] act0, act1;
    logic [31:0] sc0, fe0, sc1, fe1;
    int n_chk = 0, n_fail = 0;
    int mrem[2], frem[2];
    logic [31:0] msc[2], mfe[2];

    always #5 clk = ~clk;

    hazard_ctrl #(.MUL_LAT(4), .FETCH_LAT(3)) u0 (
        .clk(clk), .rst(rst), .ID_vld(ID_vld), .ID_mux_sel(ID_mux_sel), .ID_EX_vld(ID_EX_vld),
        .ID_EX_is_load(ID_EX_is_load), .ID_EX_is_mul(ID_EX_is_mul), .EX_br_taken(EX_br_taken),
        .PC_stall(act0[6]), .IF_ID_stall(act0[5]), .IF_ID_flush(act0[4]), .ID_EX_stall(act0[3]),
        .ID_EX_bubble(act0[2]), .EX_MEM_bubble(act0[1]), .EX_mul_last(act0[0]),
        .stall_cycles(sc0), .flush_events(fe0));

    hazard_ctrl #(.MUL_LAT(8), .FETCH_LAT(1)) u1 (
        .clk(clk), .rst(rst), .ID_vld(ID_vld), .ID_mux_sel(ID_mux_sel), .ID_EX_vld(ID_EX_vld),
        .ID_EX_is_load(ID_EX_is_load), .ID_EX_is_mul(ID_EX_is_mul), .EX_br_taken(EX_br_taken),
        .PC_stall(act1[6]), .IF_ID_stall(act1[5]), .IF_ID_flush(act1[4]), .ID_EX_stall(act1[3]),
        .ID_EX_bubble(act1[2]), .EX_MEM_bubble(act1[1]), .EX_mul_last(act1[0]),
        .stall_cycles(sc1), .flush_events(fe1));

    // Reference: mr = EX cycles left for the multiply in flight, fr = killed fetch slots still to come.
    function automatic logic [6:0] m_eval(input int ml, input int fl, input int mr, input int fr,
                                          output int nm, output int nf, output logic brk);
        logic lu;
        nm  = mr;
        nf  = fr;
        brk = 1'b0;
        lu  = ID_vld && ID_EX_vld && ID_EX_is_load &&
              (ID_mux_sel[8:6] == SEL_F1 || ID_mux_sel[5:3] == SEL_F1 || ID_mux_sel[2:0] == SEL_F1);
        if (mr > 0) begin
            nm = mr - 1;
            return (mr == 1) ? O_LAST : O_MUL;
        end
        if (fr > 0) begin
            nf = fr - 1;
            return O_FL;
        end
        if (ID_EX_vld && EX_br_taken) begin
            brk = 1'b1;
            nf  = fl - 1;
            return O_BR;
        end
        if (ID_EX_vld && ID_EX_is_mul) begin
            nm = ml - 1;
            return (ml == 1) ? O_LAST : O_MUL;
        end
        return lu ? O_LU : 7'd0;
    endfunction

    always @(posedge clk or posedge rst) begin : mdl
        logic [6:0] o;
        int nm, nf;
        logic b;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                mrem[k] = 0;
                frem[k] = 0;
                msc[k]  = 32'd0;
                mfe[k]  = 32'd0;
            end else begin
                o = m_eval(k == 0 ? 4 : 8, k == 0 ? 3 : 1, mrem[k], frem[k], nm, nf, b);
                mrem[k] = nm;
                frem[k] = nf;
                msc[k]  = msc[k] + {31'd0, o[6]};
                mfe[k]  = mfe[k] + {31'd0, b};
            end
        end
    end

    task automatic idle();
        ID_vld = 0; ID_EX_vld = 0; ID_EX_is_load = 0; ID_EX_is_mul = 0; EX_br_taken = 0; ID_mux_sel = 9'd0;
    endtask

    task automatic apply_reset();
        idle();
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        n_chk++; if (act0 !== 7'd0) begin n_fail++; $display("FAIL reset_out0: got %b expected 0", act0); end
        n_chk++; if (act1 !== 7'd0) begin n_fail++; $display("FAIL reset_out1: got %b expected 0", act1); end
        n_chk++; if (sc0 !== 32'd0) begin n_fail++; $display("FAIL reset_stall_cycles: got %0d expected 0", sc0); end
        n_chk++; if (fe0 !== 32'd0) begin n_fail++; $display("FAIL reset_flush_events: got %0d expected 0", fe0); end
        @(posedge clk); #1;
    endtask

    task automatic test_load_use();
        apply_reset();
        ID_vld = 1; ID_EX_vld = 1; ID_EX_is_load = 1; ID_mux_sel = {SEL_F1, SEL_IMM, SEL_0};
        @(negedge clk);
        n_chk++; if (act0 !== O_LU) begin n_fail++; $display("FAIL load_use_c0: got %b expected %b", act0, O_LU); end
        @(posedge clk); #1;
        ID_EX_is_load = 0; ID_mux_sel = {SEL_F2, SEL_IMM, SEL_0};
        @(negedge clk);
        n_chk++; if (act0 !== 7'd0) begin n_fail++; $display("FAIL load_use_c1: got %b expected 0", act0); end
        n_chk++; if (sc0 !== 32'd1) begin n_fail++; $display("FAIL load_use_stall_cycles: got %0d expected 1", sc0); end
        @(posedge clk); #1;
    endtask

    task automatic test_mul();
        logic [6:0] e;
        apply_reset();
        for (int c = 0; c < 5; c++) begin
            ID_EX_vld = c < 4; ID_EX_is_mul = c < 4;
            e = (c < 3) ? O_MUL : (c == 3) ? O_LAST : 7'd0;
            @(negedge clk);
            n_chk++; if (act0 !== e) begin n_fail++; $display("FAIL mul_c%0d: got %b expected %b", c, act0, e); end
            @(posedge clk); #1;
        end
        n_chk++; if (sc0 !== 32'd3) begin n_fail++; $display("FAIL mul_stall_cycles: got %0d expected 3", sc0); end
    endtask

    task automatic test_back_to_back();
        logic [6:0] e;
        apply_reset();
        for (int c = 0; c < 9; c++) begin
            ID_EX_vld = c < 8; ID_EX_is_mul = c < 8;
            e = (c == 8) ? 7'd0 : (c % 4 == 3) ? O_LAST : O_MUL;
            @(negedge clk);
            n_chk++; if (act0 !== e) begin n_fail++; $display("FAIL b2b_c%0d: got %b expected %b", c, act0, e); end
            @(posedge clk); #1;
        end
        n_chk++; if (sc0 !== 32'd6) begin n_fail++; $display("FAIL b2b_stall_cycles: got %0d expected 6", sc0); end
    endtask

    task automatic test_branch();
        logic [6:0] e0, e1;
        apply_reset();
        for (int c = 0; c < 4; c++) begin
            ID_EX_vld = c == 0; EX_br_taken = c == 0;
            e0 = (c == 0) ? O_BR : (c < 3) ? O_FL : 7'd0;
            e1 = (c == 0) ? O_BR : 7'd0;
            @(negedge clk);
            n_chk++; if (act0 !== e0) begin n_fail++; $display("FAIL br_fl3_c%0d: got %b expected %b", c, act0, e0); end
            n_chk++; if (act1 !== e1) begin n_fail++; $display("FAIL br_fl1_c%0d: got %b expected %b", c, act1, e1); end
            @(posedge clk); #1;
        end
        n_chk++; if (fe0 !== 32'd1) begin n_fail++; $display("FAIL br_flush_events: got %0d expected 1", fe0); end
        n_chk++; if (sc0 !== 32'd0) begin n_fail++; $display("FAIL br_stall_cycles: got %0d expected 0", sc0); end
    endtask

    task automatic test_flush_beats_lu();
        logic [6:0] e;
        apply_reset();
        ID_vld = 1; ID_EX_vld = 1; ID_EX_is_load = 1; ID_mux_sel = {SEL_F1, SEL_IMM, SEL_0};
        for (int c = 0; c < 3; c++) begin
            EX_br_taken = c == 0;
            e = (c == 0) ? O_BR : O_FL;
            @(negedge clk);
            n_chk++; if (act0 !== e) begin n_fail++; $display("FAIL flush_vs_lu_c%0d: got %b expected %b", c, act0, e); end
            @(posedge clk); #1;
        end
        n_chk++; if (sc0 !== 32'd0) begin n_fail++; $display("FAIL flush_vs_lu_stall_cycles: got %0d expected 0", sc0); end
        n_chk++; if (fe0 !== 32'd1) begin n_fail++; $display("FAIL flush_vs_lu_flush_events: got %0d expected 1", fe0); end
    endtask

    task automatic test_reset_mid_mul();
        apply_reset();
        ID_EX_vld = 1; ID_EX_is_mul = 1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_chk++; if (act1 !== O_MUL) begin n_fail++; $display("FAIL rst_mul_pre_c%0d: got %b expected %b", c, act1, O_MUL); end
            if (c < 2) begin @(posedge clk); #1; end
        end
        idle();
        rst = 1;
        #1;
        n_chk++; if (act1 !== 7'd0) begin n_fail++; $display("FAIL rst_mul_async_out: got %b expected 0", act1); end
        n_chk++; if (sc1 !== 32'd0) begin n_fail++; $display("FAIL rst_mul_async_stall_cycles: got %0d expected 0", sc1); end
        @(posedge clk); #1;
        rst = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_chk++; if (act1 !== 7'd0) begin n_fail++; $display("FAIL rst_mul_post_c%0d: got %b expected 0", c, act1); end
            @(posedge clk); #1;
        end
        ID_vld = 1; ID_EX_vld = 1; ID_EX_is_load = 1; ID_mux_sel = {SEL_0, SEL_F1, SEL_0};
        @(negedge clk);
        n_chk++; if (act1 !== O_LU) begin n_fail++; $display("FAIL rst_mul_run_lu: got %b expected %b", act1, O_LU); end
        @(posedge clk); #1;
        idle();
    endtask

    task automatic test_random();
        logic [6:0] e0, e1;
        int nm, nf;
        logic b;
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            ID_vld        = $urandom_range(0, 3) != 0;
            ID_EX_vld     = $urandom_range(0, 3) != 0;
            ID_EX_is_mul  = $urandom_range(0, 4) == 0;
            ID_EX_is_load = !ID_EX_is_mul && $urandom_range(0, 2) == 0;
            EX_br_taken   = $urandom_range(0, 5) == 0;
            ID_mux_sel    = {3'($urandom_range(0, 4)), 3'($urandom_range(0, 4)), 3'($urandom_range(0, 4))};
            @(negedge clk);
            e0 = m_eval(4, 3, mrem[0], frem[0], nm, nf, b);
            e1 = m_eval(8, 1, mrem[1], frem[1], nm, nf, b);
            n_chk++; if (act0 !== e0) begin n_fail++; $display("FAIL rand_out0_c%0d: got %b expected %b", c, act0, e0); end
            n_chk++; if (act1 !== e1) begin n_fail++; $display("FAIL rand_out1_c%0d: got %b expected %b", c, act1, e1); end
            n_chk++; if (sc0 !== msc[0] || fe0 !== mfe[0])
                begin n_fail++; $display("FAIL rand_cnt0_c%0d: got %0d/%0d expected %0d/%0d", c, sc0, fe0, msc[0], mfe[0]); end
            n_chk++; if (sc1 !== msc[1] || fe1 !== mfe[1])
                begin n_fail++; $display("FAIL rand_cnt1_c%0d: got %0d/%0d expected %0d/%0d", c, sc1, fe1, msc[1], mfe[1]); end
            @(posedge clk); #1;
        end
        idle();
    endtask

    initial begin
        #1;
        test_reset();
        test_load_use();
        test_mul();
        test_back_to_back();
        test_branch();
        test_flush_beats_lu();
        test_reset_mid_mul();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage in-order RV32IM core. It watches the decode outputs and the ID/EX pipeline register and generates stall, bubble and flush controls for the PC, IF/ID, ID/EX and EX/MEM registers. Three cases are sequenced:
- load-use stalls that forwarding cannot cover;
- multi-cycle occupancy of the EX-stage multiplier;
- control-flow flushes on taken branches and jumps resolved in EX.

## Interface
- `MUL_LAT`, 4: cycles a MUL/MULH/MULHSU/MULHU occupies EX; legal range 1..15.
- `FETCH_LAT`, 1: cycles from PC redirect to a valid fetch; legal range 1..4.

- `clk` input 1: core clock; all state updates on its rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `ID_vld` input 1: decoded instruction in ID is valid.
- `ID_mux_sel` input 9: {opa_sel, opb_sel, din_sel} from decode, after forwarding overrides.
- `ID_EX_vld` input 1: instruction in EX is valid.
- `ID_EX_is_load` input 1: EX instruction is a load (mem_cmd MSB 0, not `MEM_NONE`).
- `ID_EX_is_mul` input 1: EX alu_func is one of the four `ALU_MUL*` codes.
- `EX_br_taken` input 1: EX resolved a taken branch or jump this cycle.
- `PC_stall` output 1: hold the PC.
- `IF_ID_stall` output 1: hold IF/ID.
- `IF_ID_flush` output 1: load IF/ID with an invalid instruction.
- `ID_EX_stall` output 1: hold ID/EX.
- `ID_EX_bubble` output 1: load ID/EX with a bubble (vld=0, rd=`ZERO_REG`, `MEM_NONE`).
- `EX_MEM_bubble` output 1: load EX/MEM with a bubble.
- `EX_mul_last` output 1: final EX cycle of a multiply; the result is valid.
- `stall_cycles` output 32: count of cycles with `PC_stall`=1.
- `flush_events` output 32: count of taken redirects.

## Operation
- The FSM has three states: RUN, MUL_BUSY, FLUSH. A shared down-counter `cnt` is 4 bits wide.
- Load-use (RUN only, combinational):
  - Trigger: `ID_vld` & `ID_EX_vld` & `ID_EX_is_load` & (any 3-bit field of `ID_mux_sel` == `SEL_F1`).
  - Response: `PC_stall`=`IF_ID_stall`=`ID_EX_bubble`=1 for exactly one cycle.
  - Next cycle the load is in MEM and decode re-selects `SEL_F2`, so no second stall occurs. No state change.
- Multiply:
  - Trigger in RUN: `ID_EX_vld` & `ID_EX_is_mul`.
  - If `MUL_LAT`==1: `EX_mul_last`=1 and there is no stall.
  - Otherwise: assert `PC_stall`, `IF_ID_stall`, `ID_EX_stall`, `EX_MEM_bubble`; load `cnt`=`MUL_LAT`-2; go to MUL_BUSY.
  - In MUL_BUSY with `cnt`!=0: same four stall signals; decrement `cnt`.
  - In MUL_BUSY with `cnt`==0: no stalls, `EX_mul_last`=1, go to RUN.
- Flush:
  - Trigger in RUN: `EX_br_taken` & `ID_EX_vld`.
  - Response: `IF_ID_flush`=`ID_EX_bubble`=1; `flush_events`++.
  - If `FETCH_LAT`>1: load `cnt`=`FETCH_LAT`-2 and go to FLUSH.
  - In FLUSH: `IF_ID_flush`=1 each cycle; decrement `cnt`; return to RUN after the cycle with `cnt`==0.
  - A load-use stall is suppressed while in FLUSH.
- Priority in RUN: flush > multiply > load-use.
  - A taken branch suppresses load-use stall signals in the same cycle, because the ID instruction is killed.
  - `EX_br_taken` is ignored in MUL_BUSY, since EX holds the multiply.
- Back-to-back multiplies: the second enters EX in the cycle after `EX_mul_last` and retriggers from RUN.
- `stall_cycles` increments every cycle `PC_stall`=1.
- Both counters wrap modulo 2^32 with no saturation.

## Timing
- All control outputs are combinational from the current state and inputs, valid within the same cycle. State, `cnt` and the perf counters are registered.
- Reset (asynchronous, any state): state=RUN, `cnt`=0, `stall_cycles`=0, `flush_events`=0. All control outputs evaluate to 0 with inputs idle.
- Reset mid-MUL_BUSY or mid-FLUSH aborts the sequence immediately; no pending stall survives.
- A multiply with `MUL_LAT`=N holds the pipeline N-1 cycles and retires to MEM at the edge ending cycle N.
- Load-use costs 1 cycle.
- A taken redirect costs 1+(`FETCH_LAT`-1) killed fetch slots plus 1 ID bubble.

## Test plan
- Load-use:
  - Stimulus: `ID_EX_is_load`=1, `ID_EX_vld`=1, `ID_mux_sel`={`SEL_F1`,`SEL_IMM`,`SEL_0`}, `ID_vld`=1.
  - Required: `PC_stall`/`IF_ID_stall`/`ID_EX_bubble`=1 for 1 cycle; `stall_cycles`=1.
- Multiply, `MUL_LAT`=4:
  - Stimulus: `ID_EX_is_mul` pulse.
  - Required: stalls and `EX_MEM_bubble` for cycles 0-2, `EX_mul_last`=1 in cycle 3, then RUN; `stall_cycles`=3.
- Back-to-back multiplies, `MUL_LAT`=4:
  - Stimulus: two multiplies in consecutive slots.
  - Required: 6 stall cycles total, `EX_mul_last` pulses in cycles 3 and 7.
- Taken branch, `FETCH_LAT`=3:
  - Stimulus: `EX_br_taken` with `ID_EX_vld`=1.
  - Required: `IF_ID_flush`=1 for 3 cycles, `ID_EX_bubble`=1 in cycle 0 only; `flush_events`=1.
- Flush beats load-use:
  - Stimulus: `EX_br_taken` and load-use conditions asserted in the same cycle.
  - Required: flush only; `PC_stall`=0.
- Reset mid-multiply:
  - Stimulus: `MUL_LAT`=8; assert `rst` in cycle 2 of a multiply.
  - Required: all outputs 0 asynchronously; after release, state=RUN with no residual stall.
